// File: rtl/int_ctrl_if.sv
// int_ctrl_if -- port bundle between the interrupt controller and its
// surroundings (interrupt sources, csr_reg, clint and the config bus).
//
// Offer handshake: int_flag_o acts as "valid". It is one-hot and stays
// stable, together with claim_id_o, until clint answers with a one-cycle
// int_ack_i pulse ("ready"). The offer may also be withdrawn (int_flag_o
// returns to zero without an ack) when interrupts are globally or locally
// disabled. After an ack, in_service_o stays high until clint reports the end
// of the return sequence with a one-cycle mret_i pulse. Config writes are
// single-cycle strobes with no back-pressure. Reads are combinational.
//
// Signals:
//   src_i[8]            raw interrupt lines, bit k = source k
//   global_int_en_i     mstatus.MIE
//   clint_busy_i        clint is sequencing CSR writes; no new offer
//   int_ack_i           offer accepted (pulse)
//   mret_i              return sequence complete (pulse)
//   cfg_we_i            config write strobe
//   cfg_addr_i[2]       0 = ENABLE, 1 = PENDING, 2 = STATUS, 3 = reserved
//   cfg_wdata_i[8]      config write data
//   cfg_rdata_o[32]     read data for cfg_addr_i
//   int_flag_o[8]       one-hot offer, zero when none
//   claim_id_o[3]       source offered or in service
//   in_service_o        high from ack until mret
//   state_dbg[3]        controller state (one-hot), for observation
interface int_ctrl_if;
  logic [7:0]  src_i;
  logic        global_int_en_i;
  logic        clint_busy_i;
  logic        int_ack_i;
  logic        mret_i;
  logic        cfg_we_i;
  logic [1:0]  cfg_addr_i;
  logic [7:0]  cfg_wdata_i;
  logic [31:0] cfg_rdata_o;
  logic [7:0]  int_flag_o;
  logic [2:0]  claim_id_o;
  logic        in_service_o;
  logic [2:0]  state_dbg;

  modport master (
    output src_i, global_int_en_i, clint_busy_i, int_ack_i, mret_i,
    output cfg_we_i, cfg_addr_i, cfg_wdata_i,
    input  cfg_rdata_o, int_flag_o, claim_id_o, in_service_o, state_dbg
  );

  modport slave (
    input  src_i, global_int_en_i, clint_busy_i, int_ack_i, mret_i,
    input  cfg_we_i, cfg_addr_i, cfg_wdata_i,
    output cfg_rdata_o, int_flag_o, claim_id_o, in_service_o, state_dbg
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl -- 8-source edge-triggered interrupt controller with fixed
// priority (source 0 highest) and a single, non-nesting offer to clint.
//
// Ports:
//   clk   core clock, rising edge
//   rst   synchronous, active-high reset
//   bus   int_ctrl_if.slave: sources, enables, clint handshake, config bus,
//         offer/claim/in-service outputs and the state debug view
module int_ctrl (
  input  logic         clk,
  input  logic         rst,
  int_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    ASSERT  = 3'b010,
    SERVICE = 3'b100
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  src_q;
  // arm[k] is set once source k has been seen low. A line that is high
  // while reset is released must drop before it can produce an edge.
  logic [7:0]  arm;
  logic [7:0]  pending;
  logic [7:0]  pending_nxt;
  logic [7:0]  enable;
  logic [7:0]  edges;
  logic [7:0]  cand;
  logic [7:0]  clr_mask;
  logic [2:0]  claim;
  logic [2:0]  claim_nxt;
  logic [2:0]  winner;
  logic        ack_clr;
  logic        offering;
  logic        in_service;

  assign edges = bus.src_i & ~src_q & arm;
  assign cand  = pending & enable;

  // Fixed priority: scan from the top so the lowest set index wins.
  always_comb begin
    winner = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (cand[k]) winner = 3'(k);
    end
  end

  // Next state, claim latch and ack-driven pending clear.
  always_comb begin
    state_nxt = state;
    claim_nxt = claim;
    ack_clr   = 1'b0;
    case (state)
      IDLE: begin
        if ((cand != 8'd0) && bus.global_int_en_i && !bus.clint_busy_i) begin
          state_nxt = ASSERT;
          claim_nxt = winner;
        end
      end
      ASSERT: begin
        // Ack takes precedence over a withdraw in the same cycle.
        if (bus.int_ack_i) begin
          state_nxt = SERVICE;
          ack_clr   = 1'b1;
        end else if (!bus.global_int_en_i || !enable[claim]) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (bus.mret_i) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        claim_nxt = 3'd0;
      end
    endcase
  end

  // Edges are OR-ed in after the clears so a new edge always survives a
  // simultaneous ack or write-1-to-clear of the same bit.
  always_comb begin
    clr_mask = 8'd0;
    if (ack_clr) clr_mask = 8'd1 << claim;
    if (bus.cfg_we_i && (bus.cfg_addr_i == 2'd1)) clr_mask = clr_mask | bus.cfg_wdata_i;
    pending_nxt = (pending & ~clr_mask) | edges;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 8'd0;
      enable  <= 8'd0;
      src_q   <= 8'd0;
      arm     <= ~bus.src_i;
      claim   <= 3'd0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      src_q   <= bus.src_i;
      arm     <= arm | ~bus.src_i;
      claim   <= claim_nxt;
      if (bus.cfg_we_i && (bus.cfg_addr_i == 2'd0)) enable <= bus.cfg_wdata_i;
    end
  end

  // Outputs are decoded from the legal states only, so any stray encoding
  // presents no offer and no service.
  assign offering   = (state == ASSERT);
  assign in_service = (state == SERVICE);

  assign bus.int_flag_o   = offering ? (8'd1 << claim) : 8'd0;
  assign bus.claim_id_o   = claim;
  assign bus.in_service_o = in_service;
  assign bus.state_dbg    = state;

  always_comb begin
    case (bus.cfg_addr_i)
      2'd0:    bus.cfg_rdata_o = {24'd0, enable};
      2'd1:    bus.cfg_rdata_o = {24'd0, pending};
      2'd2:    bus.cfg_rdata_o = {27'd0, in_service, claim, offering};
      default: bus.cfg_rdata_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_ctrl_if bus ();

  int_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- stimulus variables ----------------
  logic [7:0] d_src   = 8'd0;
  logic       d_gie   = 1'b0;
  logic       d_busy  = 1'b0;
  logic       d_ack   = 1'b0;
  logic       d_mret  = 1'b0;
  logic       d_we    = 1'b0;
  logic [1:0] d_addr  = 2'd1;
  logic [7:0] d_wdata = 8'd0;
  logic       d_rst   = 1'b1;

  // ---------------- reference model ----------------
  // phase: 0 = no offer, 1 = offering, 2 = in service
  logic [7:0] m_pending = 8'd0;
  logic [7:0] m_enable  = 8'd0;
  logic [7:0] m_src_q   = 8'd0;
  logic [7:0] m_arm     = 8'd0;
  logic [2:0] m_claim   = 3'd0;
  int         m_phase   = 0;

  // ---------------- scoreboard ----------------
  logic [7:0]  offer_q[$];
  logic [43:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [7:0] v);
    for (int k = 0; k < 8; k++) if (v[k]) return 3'(k);
    return 3'd0;
  endfunction

  task automatic model_step();
    logic [7:0]  edges;
    logic [7:0]  clr;
    logic [7:0]  cand;
    logic [7:0]  flag;
    logic [31:0] rdata;
    int          nphase;
    if (d_rst) begin
      m_pending = 8'd0;
      m_enable  = 8'd0;
      m_src_q   = 8'd0;
      m_arm     = ~d_src;
      m_claim   = 3'd0;
      m_phase   = 0;
    end else begin
      edges  = d_src & ~m_src_q & m_arm;
      cand   = m_pending & m_enable;
      clr    = 8'd0;
      nphase = m_phase;
      if (m_phase == 0) begin
        if (cand != 0 && d_gie && !d_busy) begin
          nphase  = 1;
          m_claim = lowest(cand);
          offer_q.push_back(8'd1 << m_claim);
        end
      end else if (m_phase == 1) begin
        if (d_ack) begin
          nphase = 2;
          clr[m_claim] = 1'b1;
        end else if (!d_gie || !m_enable[m_claim]) begin
          nphase = 0;
        end
      end else if (d_mret) begin
        nphase = 0;
      end
      if (d_we && d_addr == 2'd1) clr = clr | d_wdata;
      if (d_we && d_addr == 2'd0) m_enable = d_wdata;
      m_pending = (m_pending & ~clr) | edges;
      m_src_q   = d_src;
      m_arm     = m_arm | ~d_src;
      m_phase   = nphase;
    end
    flag = (m_phase == 1) ? (8'd1 << m_claim) : 8'd0;
    case (d_addr)
      2'd0:    rdata = {24'd0, m_enable};
      2'd1:    rdata = {24'd0, m_pending};
      2'd2:    rdata = {27'd0, (m_phase == 2), m_claim, (m_phase == 1)};
      default: rdata = 32'd0;
    endcase
    exp_q.push_back({flag, m_claim, (m_phase == 2), rdata});
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    bus.src_i           = d_src;
    bus.global_int_en_i = d_gie;
    bus.clint_busy_i    = d_busy;
    bus.int_ack_i       = d_ack;
    bus.mret_i          = d_mret;
    bus.cfg_we_i        = d_we;
    bus.cfg_addr_i      = d_addr;
    bus.cfg_wdata_i     = d_wdata;
    rst                 = d_rst;
    model_step();
    @(negedge clk);
    d_ack  = 1'b0;
    d_mret = 1'b0;
    d_we   = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (m_phase != p && n < 30) begin
      tick();
      n++;
    end
    if (m_phase != p) begin
      bad++;
      $display("FAIL wait_phase got=%0d want=%0d", m_phase, p);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] v);
    logic [1:0] keep;
    keep    = d_addr;
    d_we    = 1'b1;
    d_addr  = a;
    d_wdata = v;
    tick();
    d_addr  = keep;
  endtask

  // ---------------- monitor ----------------
  logic [43:0] mon_exp;
  logic [7:0]  mon_off;
  logic [7:0]  prev_flag = 8'd0;

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check("outputs", {bus.int_flag_o, bus.claim_id_o, bus.in_service_o, bus.cfg_rdata_o}, mon_exp);
    end
    if (bus.int_flag_o != 8'd0 && prev_flag == 8'd0) begin
      if (offer_q.size() > 0) begin
        mon_off = offer_q.pop_front();
        check("offer", bus.int_flag_o, mon_off);
      end else begin
        total++;
        bad++;
        $display("FAIL offer_unexpected got=%h want=none", bus.int_flag_o);
      end
    end
    prev_flag = bus.int_flag_o;
  end

  // ---------------- test sequence ----------------
  initial begin
    d_rst = 1'b1;
    tick();
    tick();
    check("reset_flag", bus.int_flag_o, 8'h00);
    check("reset_pending", bus.cfg_rdata_o, 32'h0);
    d_rst = 1'b0;
    d_gie = 1'b1;
    tick();

    // single source, latency
    cfg_write(2'd0, 8'h04);
    d_src = 8'h04; tick();
    check("lat_pending", bus.cfg_rdata_o, 32'h04);
    d_src = 8'h00; tick();
    check("lat_flag", bus.int_flag_o, 8'h04);
    check("lat_claim", bus.claim_id_o, 3'd2);
    d_ack = 1'b1; tick();
    check("ack_in_service", bus.in_service_o, 1'b1);
    check("ack_pending", bus.cfg_rdata_o, 32'h0);
    d_mret = 1'b1; tick();

    // priority between simultaneous edges
    cfg_write(2'd0, 8'hFF);
    d_src = 8'h22; tick();
    d_src = 8'h00; tick();
    check("prio_first", bus.int_flag_o, 8'h02);
    d_ack = 1'b1; tick();
    d_mret = 1'b1; tick();
    wait_phase(1);
    check("prio_second", bus.int_flag_o, 8'h20);
    d_ack = 1'b1; tick();
    d_mret = 1'b1; tick();

    // withdraw on global disable, re-offer afterwards
    d_src = 8'h08; tick();
    d_src = 8'h00;
    wait_phase(1);
    check("wd_claim", bus.claim_id_o, 3'd3);
    d_gie = 1'b0; tick();
    check("wd_flag", bus.int_flag_o, 8'h00);
    check("wd_pending", bus.cfg_rdata_o, 32'h08);
    tick();
    d_gie = 1'b1;
    wait_phase(1);
    check("wd_reoffer", bus.int_flag_o, 8'h08);
    d_ack = 1'b1; tick();
    d_mret = 1'b1; tick();

    // no nesting while in service
    d_src = 8'h04; tick();
    d_src = 8'h00;
    wait_phase(1);
    d_ack = 1'b1; tick();
    d_src = 8'h01; tick();
    d_src = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    check("nest_none", bus.int_flag_o, 8'h00);
    d_mret = 1'b1; tick();
    check("nest_after_mret", bus.int_flag_o, 8'h00);
    tick();
    check("nest_offer", bus.int_flag_o, 8'h01);
    d_ack = 1'b1; tick();
    d_mret = 1'b1; tick();

    // edge and write-1-to-clear in the same cycle
    d_gie = 1'b0;
    d_src = 8'h40; d_we = 1'b1; d_addr = 2'd1; d_wdata = 8'h40; tick();
    check("set_wins", bus.cfg_rdata_o, 32'h40);
    d_src = 8'h00;
    cfg_write(2'd1, 8'h40);
    check("w1c", bus.cfg_rdata_o, 32'h00);
    d_gie = 1'b1;

    // reset in service
    d_src = 8'h02; tick();
    d_src = 8'h00;
    wait_phase(1);
    d_ack = 1'b1; tick();
    d_rst = 1'b1; tick();
    d_rst = 1'b0;
    check("rst_svc", {bus.int_flag_o, bus.claim_id_o, bus.in_service_o}, 12'h0);
    d_ack = 1'b1; tick();
    d_mret = 1'b1; tick();
    check("rst_svc_ignored", bus.in_service_o, 1'b0);

    // source held high across reset release
    d_gie = 1'b0;
    d_src = 8'h10; tick();
    d_rst = 1'b1; tick();
    d_rst = 1'b0; tick(); tick();
    check("held_no_edge", bus.cfg_rdata_o, 32'h00);
    d_src = 8'h00; tick();
    d_src = 8'h10; tick();
    check("held_then_edge", bus.cfg_rdata_o, 32'h10);
    d_src = 8'h00;
    cfg_write(2'd1, 8'hFF);
    cfg_write(2'd0, 8'hFF);
    d_gie = 1'b1;

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      d_src   = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
      d_gie   = ($urandom_range(0, 9) != 0);
      d_busy  = ($urandom_range(0, 7) == 0);
      d_ack   = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      d_mret  = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      d_we    = ($urandom_range(0, 9) == 0);
      d_addr  = 2'($urandom_range(0, 3));
      d_wdata = 8'($urandom);
      d_rst   = ($urandom_range(0, 249) == 0);
      tick();
    end

    d_rst  = 1'b0;
    d_gie  = 1'b0;
    d_src  = 8'h00;
    d_busy = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("offers_drained", 64'(offer_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
